// File: rtl/saturn_jump_sequencer_pkg.sv
// Shared definitions for the Saturn jump sequencer: decoder instruction types,
// jump length codes and sequencer state encoding.
package saturn_jump_sequencer_pkg;

  localparam logic [3:0] INSTR_TYPE_NOP  = 4'h0;
  localparam logic [3:0] INSTR_TYPE_ALU  = 4'h1;
  localparam logic [3:0] INSTR_TYPE_MEM  = 4'h2;
  localparam logic [3:0] INSTR_TYPE_JUMP = 4'h3;

  localparam logic [2:0] JUMP_LEN_REL = 3'd2;
  localparam logic [2:0] JUMP_LEN_ABS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/saturn_rstk.sv
// Hardware return stack: circular LIFO that overwrites the oldest entry when a
// push arrives while full. Popping an empty stack is a no-op.
module saturn_rstk #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           data,
  output logic [$clog2(DEPTH):0] depth,
  output logic [W-1:0]           top
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_ptr;
  logic [PW:0]   count;

  assign top_ptr = ptr - PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem   <= '{default: '0};
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      // ptr wraps naturally, so a full push lands on the oldest slot
      mem[ptr] <= data;
      ptr      <= ptr + PW'(1);
      if (count != (PW+1)'(DEPTH)) count <= count + (PW+1)'(1);
    end else if (pop && count != '0) begin
      ptr   <= top_ptr;
      count <= count - (PW+1)'(1);
    end
  end

  assign depth = count;
  assign top   = (count == '0) ? '0 : mem[top_ptr];

endmodule

// File: rtl/saturn_jump_sequencer.sv
// Sequences jump instructions: gathers address nibbles, computes the relative or
// absolute target, strobes a PC load and manages the return stack.
module saturn_jump_sequencer
  import saturn_jump_sequencer_pkg::*;
#(
  parameter int unsigned RSTK_DEPTH = 8,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clk_en,
  input  logic [3:0]                  i_phases,
  input  logic                        i_bus_busy,
  input  logic [3:0]                  i_nibble,
  input  logic [3:0]                  i_instr_type,
  input  logic                        i_instr_execute,
  input  logic [2:0]                  i_jump_length,
  input  logic                        i_push_pc,
  input  logic [ADDR_W-1:0]           i_instr_pc,
  input  logic                        i_rtn_req,
  output logic                        o_load_pc,
  output logic [ADDR_W-1:0]           o_new_pc,
  output logic                        o_busy,
  output logic [$clog2(RSTK_DEPTH):0] o_rstk_depth,
  output logic [ADDR_W-1:0]           o_rstk_top,
  output logic                        o_error
);

  localparam int unsigned NIBS = ADDR_W / 4;

  seq_state_t        state, state_n;
  logic [2:0]        cnt, cnt_n, len, len_n;
  logic              push_q, push_n;
  logic [ADDR_W-1:0] acc, acc_n, base, base_n;
  logic [ADDR_W-1:0] new_pc, new_pc_n;
  logic              load_pc, load_n, error, error_n, busy;
  logic              rs_push, rs_pop;
  logic              en, jump_req;
  logic [1:0]        oplen;
  logic [ADDR_W-1:0] target_rel, ret_addr;
  logic              unused_phases;

  assign unused_phases = ^i_phases[1:0];

  assign en       = i_clk_en && !i_bus_busy;
  assign jump_req = i_phases[3] && i_instr_execute && (i_instr_type == INSTR_TYPE_JUMP);

  assign oplen      = (len == JUMP_LEN_REL) ? 2'd1 : 2'd2;
  assign target_rel = base + ADDR_W'(1) + {{(ADDR_W-12){acc[11]}}, acc[11:0]};
  assign ret_addr   = base + ADDR_W'(oplen) + ADDR_W'(len) + ADDR_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      len     <= '0;
      push_q  <= 1'b0;
      acc     <= '0;
      base    <= '0;
      new_pc  <= '0;
      load_pc <= 1'b0;
      error   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      len     <= len_n;
      push_q  <= push_n;
      acc     <= acc_n;
      base    <= base_n;
      new_pc  <= new_pc_n;
      load_pc <= load_n;
      error   <= error_n;
      busy    <= (state_n != ST_IDLE);
    end
  end

  // Next-state, datapath and stack control
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    len_n    = len;
    push_n   = push_q;
    acc_n    = acc;
    base_n   = base;
    new_pc_n = new_pc;
    load_n   = i_clk_en ? 1'b0 : load_pc;
    error_n  = error;
    rs_push  = 1'b0;
    rs_pop   = 1'b0;
    if (en) begin
      if (state != ST_IDLE && (jump_req || i_rtn_req)) error_n = 1'b1;
      case (state)
        ST_IDLE: begin
          if (jump_req) begin
            state_n = ST_COLLECT;
            len_n   = i_jump_length;
            push_n  = i_push_pc;
            base_n  = i_instr_pc;
            cnt_n   = '0;
            acc_n   = '0;
          end else if (i_rtn_req) begin
            new_pc_n = o_rstk_top;
            load_n   = 1'b1;
            rs_pop   = 1'b1;
          end
        end
        ST_COLLECT: begin
          if (i_phases[2]) begin
            for (int unsigned k = 0; k < NIBS; k++) begin
              if (cnt == 3'(k)) acc_n[4*k +: 4] = i_nibble;
            end
            cnt_n = cnt + 3'd1;
            if (cnt == len) state_n = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          state_n = ST_IDLE;
          if (len == JUMP_LEN_REL || len == JUMP_LEN_ABS) begin
            new_pc_n = (len == JUMP_LEN_REL) ? target_rel : acc;
            load_n   = 1'b1;
            rs_push  = push_q;
          end else begin
            error_n = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  saturn_rstk #(
    .DEPTH (RSTK_DEPTH),
    .W     (ADDR_W)
  ) u_rstk (
    .clk   (i_clk),
    .reset (i_reset),
    .push  (rs_push),
    .pop   (rs_pop),
    .data  (ret_addr),
    .depth (o_rstk_depth),
    .top   (o_rstk_top)
  );

  assign o_load_pc = load_pc;
  assign o_new_pc  = new_pc;
  assign o_busy    = busy;
  assign o_error   = error;

endmodule

// File: tb/tb_saturn_jump_sequencer.sv
// Randomized self-checking bench for saturn_jump_sequencer against a queue-based
// model of jump targets and the return stack.
module tb_saturn_jump_sequencer;
  import saturn_jump_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clk_en, bus_busy, instr_execute, push_pc, rtn_req;
  logic [3:0]  phases, nibble, instr_type;
  logic [2:0]  jump_length;
  logic [19:0] instr_pc;
  logic        load_pc, busy, error;
  logic [19:0] new_pc, rstk_top;
  logic [3:0]  rstk_depth;

  int vectors = 0;
  int miscompares = 0;
  int tcount, obs_loads, obs_load_t, cap_t;
  logic [19:0] obs_pc;
  logic [19:0] model_stk[$];

  always #5 clk = ~clk;

  saturn_jump_sequencer dut (
    .i_clk(clk), .i_reset(reset), .i_clk_en(clk_en), .i_phases(phases),
    .i_bus_busy(bus_busy), .i_nibble(nibble), .i_instr_type(instr_type),
    .i_instr_execute(instr_execute), .i_jump_length(jump_length),
    .i_push_pc(push_pc), .i_instr_pc(instr_pc), .i_rtn_req(rtn_req),
    .o_load_pc(load_pc), .o_new_pc(new_pc), .o_busy(busy),
    .o_rstk_depth(rstk_depth), .o_rstk_top(rstk_top), .o_error(error)
  );

  function automatic logic [19:0] m_target(logic [19:0] pc, int len, logic [31:0] nibs);
    int off;
    if (len == 2) begin
      off = int'(nibs[11:0]);
      if (off >= 2048) off -= 4096;
      return 20'(int'(pc) + 1 + off);
    end
    return nibs[19:0];
  endfunction

  function automatic logic [19:0] m_ret(logic [19:0] pc, int len);
    return 20'(int'(pc) + ((len == 2) ? 1 : 2) + len + 1);
  endfunction

  function automatic logic [19:0] m_top();
    return (model_stk.size() == 0) ? 20'h0 : model_stk[$];
  endfunction

  task automatic m_push(input logic [19:0] v);
    model_stk.push_back(v);
    if (model_stk.size() > 8) void'(model_stk.pop_front());
  endtask

  function automatic logic [19:0] m_pop();
    if (model_stk.size() == 0) return 20'h0;
    return model_stk.pop_back();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    tcount++;
    if (load_pc === 1'b1) begin
      obs_loads++;
      obs_pc = new_pc;
      obs_load_t = tcount;
    end
  endtask

  task automatic clear_obs();
    tcount = 0; obs_loads = 0; obs_load_t = -1; obs_pc = 20'h0; cap_t = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_stk.delete();
  endtask

  // Drives one jump; bus stall inserted before nibble stall_at, optional clk_en gaps
  task automatic do_jump(input logic [19:0] pc, input logic [2:0] len, input logic push,
                         input logic [31:0] nibs, input int stall_at, input int stall_len,
                         input bit gaps);
    clear_obs();
    instr_type = INSTR_TYPE_JUMP; instr_execute = 1'b1; phases = 4'b1000;
    jump_length = len; push_pc = push; instr_pc = pc;
    tick();
    instr_execute = 1'b0; phases = 4'b0000;
    for (int k = 0; k <= int'(len); k++) begin
      if (k == stall_at) begin
        bus_busy = 1'b1; phases = 4'b0100; nibble = 4'hA;
        for (int s = 0; s < stall_len; s++) tick();
        bus_busy = 1'b0;
      end
      if (gaps && $urandom_range(0, 1) == 1) begin
        clk_en = 1'b0; phases = 4'b0100; nibble = 4'($urandom);
        tick();
        clk_en = 1'b1; phases = 4'b0001;
        tick();
      end
      phases = 4'b0100; nibble = nibs[4*k +: 4];
      tick();
      cap_t = tcount;
      phases = 4'b0000;
    end
    for (int w = 0; w < 6; w++) tick();
  endtask

  task automatic do_pop();
    clear_obs();
    rtn_req = 1'b1;
    tick();
    rtn_req = 1'b0;
    for (int w = 0; w < 3; w++) tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({load_pc, new_pc, busy, rstk_depth, rstk_top, error} !== 47'h0) begin
      miscompares++;
      $display("FAIL reset: load=%0b pc=%h busy=%0b depth=%0d top=%h err=%0b, required all 0",
               load_pc, new_pc, busy, rstk_depth, rstk_top, error);
    end
  endtask

  task automatic test_goto_rel();
    logic [19:0] pcs [3] = '{20'h00100, 20'h00100, 20'hFFFFF};
    logic [31:0] nbs [3] = '{32'h021, 32'hFFF, 32'h002};
    logic [19:0] exp [3] = '{20'h00122, 20'h00100, 20'h00002};
    for (int i = 0; i < 3; i++) begin
      do_jump(pcs[i], JUMP_LEN_REL, 1'b0, nbs[i], -1, 0, 1'b0);
      vectors++;
      if (obs_loads != 1 || obs_pc !== exp[i] || obs_pc !== m_target(pcs[i], 2, nbs[i])) begin
        miscompares++;
        $display("FAIL goto_rel[%0d]: loads=%0d pc=%h, required 1 load pc=%h", i, obs_loads, obs_pc, exp[i]);
      end
      vectors++;
      if (obs_load_t - cap_t != 1 || rstk_depth !== 4'd0) begin
        miscompares++;
        $display("FAIL goto_latency[%0d]: latency=%0d depth=%0d, required 1 and 0", i, obs_load_t - cap_t, rstk_depth);
      end
    end
  endtask

  task automatic test_gosbvl_rtn();
    do_jump(20'h00200, JUMP_LEN_ABS, 1'b1, 32'h12345, -1, 0, 1'b0);
    m_push(m_ret(20'h00200, 4));
    vectors++;
    if (obs_loads != 1 || obs_pc !== 20'h12345 || rstk_top !== 20'h00207 || rstk_depth !== 4'd1) begin
      miscompares++;
      $display("FAIL gosbvl: loads=%0d pc=%h top=%h depth=%0d, required 1 12345 00207 1",
               obs_loads, obs_pc, rstk_top, rstk_depth);
    end
    do_pop();
    void'(m_pop());
    vectors++;
    if (obs_loads != 1 || obs_pc !== 20'h00207 || rstk_depth !== 4'd0 || obs_load_t != 1) begin
      miscompares++;
      $display("FAIL rtn: loads=%0d pc=%h depth=%0d t=%0d, required 1 00207 0 1",
               obs_loads, obs_pc, rstk_depth, obs_load_t);
    end
  endtask

  task automatic test_stack_overflow();
    logic [19:0] pc, exp;
    for (int i = 0; i < 9; i++) begin
      pc = 20'($urandom);
      do_jump(pc, JUMP_LEN_ABS, 1'b1, 32'($urandom), -1, 0, 1'b0);
      m_push(m_ret(pc, 4));
    end
    vectors++;
    if (rstk_depth !== 4'd8 || rstk_top !== m_top()) begin
      miscompares++;
      $display("FAIL overflow_depth: depth=%0d top=%h, required 8 %h", rstk_depth, rstk_top, m_top());
    end
    for (int i = 0; i < 9; i++) begin
      exp = m_pop();
      do_pop();
      vectors++;
      if (obs_loads != 1 || obs_pc !== exp || rstk_depth !== 4'(model_stk.size())) begin
        miscompares++;
        $display("FAIL overflow_pop[%0d]: pc=%h depth=%0d, required %h %0d",
                 i, obs_pc, rstk_depth, exp, model_stk.size());
      end
    end
  endtask

  task automatic test_bus_stall();
    logic [19:0] pc;
    logic [31:0] nibs;
    int t_ref;
    pc = 20'($urandom); nibs = 32'($urandom);
    do_jump(pc, JUMP_LEN_ABS, 1'b0, nibs, -1, 0, 1'b0);
    t_ref = obs_load_t;
    do_jump(pc, JUMP_LEN_ABS, 1'b0, nibs, 3, 3, 1'b0);
    vectors++;
    if (obs_loads != 1 || obs_pc !== nibs[19:0] || obs_load_t != t_ref + 3) begin
      miscompares++;
      $display("FAIL bus_stall: pc=%h t=%0d, required %h t=%0d", obs_pc, obs_load_t, nibs[19:0], t_ref + 3);
    end
  endtask

  task automatic test_reset_abort();
    clear_obs();
    instr_type = INSTR_TYPE_JUMP; instr_execute = 1'b1; phases = 4'b1000;
    jump_length = JUMP_LEN_ABS; push_pc = 1'b1; instr_pc = 20'h00300;
    tick();
    instr_execute = 1'b0;
    for (int k = 0; k < 2; k++) begin
      phases = 4'b0100; nibble = 4'(k + 1);
      tick();
    end
    phases = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_stk.delete();
    vectors++;
    if ({load_pc, new_pc, busy, rstk_depth, rstk_top, error} !== 47'h0) begin
      miscompares++;
      $display("FAIL reset_abort: load=%0b pc=%h busy=%0b depth=%0d top=%h, required all 0",
               load_pc, new_pc, busy, rstk_depth, rstk_top);
    end
    for (int w = 0; w < 5; w++) tick();
    vectors++;
    if (obs_loads != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_noload: loads=%0d busy=%0b, required 0 0", obs_loads, busy);
    end
    do_jump(20'h00100, JUMP_LEN_REL, 1'b0, 32'h021, -1, 0, 1'b0);
    vectors++;
    if (obs_loads != 1 || obs_pc !== 20'h00122) begin
      miscompares++;
      $display("FAIL post_reset_goto: loads=%0d pc=%h, required 1 00122", obs_loads, obs_pc);
    end
  endtask

  task automatic test_random();
    logic [19:0] pc, exp;
    logic [31:0] nibs;
    logic [2:0]  len;
    logic        push;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        exp = m_pop();
        do_pop();
      end else begin
        pc = 20'($urandom); nibs = 32'($urandom);
        len = ($urandom_range(0, 1) == 1) ? JUMP_LEN_ABS : JUMP_LEN_REL;
        push = 1'($urandom);
        exp = m_target(pc, int'(len), nibs);
        do_jump(pc, len, push, nibs, -1, 0, 1'b1);
        if (push) m_push(m_ret(pc, int'(len)));
      end
      vectors++;
      if (obs_loads != 1 || obs_pc !== exp || rstk_depth !== 4'(model_stk.size()) ||
          rstk_top !== m_top() || error !== 1'b0) begin
        miscompares++;
        $display("FAIL random[%0d]: loads=%0d pc=%h depth=%0d top=%h err=%0b, required 1 %h %0d %h 0",
                 i, obs_loads, obs_pc, rstk_depth, rstk_top, error, exp, model_stk.size(), m_top());
      end
    end
  endtask

  task automatic test_errors();
    int d0;
    d0 = int'(rstk_depth);
    clear_obs();
    instr_type = INSTR_TYPE_JUMP; instr_execute = 1'b1; phases = 4'b1000;
    jump_length = JUMP_LEN_REL; push_pc = 1'b0; instr_pc = 20'h00400;
    tick();
    instr_execute = 1'b0; phases = 4'b0100; nibble = 4'h2;
    tick();
    phases = 4'b0000; rtn_req = 1'b1;
    tick();
    rtn_req = 1'b0; phases = 4'b0100; nibble = 4'h0;
    tick(); tick();
    phases = 4'b0000;
    for (int w = 0; w < 6; w++) tick();
    vectors++;
    if (error !== 1'b1 || obs_loads != 1 || obs_pc !== 20'h00403 || int'(rstk_depth) != d0) begin
      miscompares++;
      $display("FAIL rtn_while_busy: err=%0b loads=%0d pc=%h depth=%0d, required 1 1 00403 %0d",
               error, obs_loads, obs_pc, rstk_depth, d0);
    end
    do_reset();
    do_jump(20'h00500, 3'd3, 1'b1, 32'h4321, -1, 0, 1'b0);
    vectors++;
    if (error !== 1'b1 || obs_loads != 0 || rstk_depth !== 4'd0) begin
      miscompares++;
      $display("FAIL bad_len: err=%0b loads=%0d depth=%0d, required 1 0 0", error, obs_loads, rstk_depth);
    end
    do_reset();
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL error_clear: err=%0b, required 0", error);
    end
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; bus_busy = 1'b0; instr_execute = 1'b0; push_pc = 1'b0;
    rtn_req = 1'b0; phases = 4'b0000; nibble = 4'h0; instr_type = INSTR_TYPE_NOP;
    jump_length = 3'd0; instr_pc = 20'h0;
    clear_obs();
    test_reset();
    test_goto_rel();
    test_gosbvl_rtn();
    test_stack_overflow();
    test_bus_stall();
    test_reset_abort();
    test_random();
    test_errors();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
